// File: rtl/ld_st_mem_unit.sv
// Load/store memory unit.
// Queues in-order loads/stores from the load/store buffer in a small FIFO.
// Runs each one against data memory over a req/ack handshake, then
// broadcasts a one-cycle completion on the CDB unless a flush dropped it.
module ld_st_mem_unit #(
  parameter int          QDEPTH    = 4,
  parameter int          ADDR_W    = 10,
  parameter logic [11:0] LW_OPCODE = 12'h023,
  parameter logic [11:0] SW_OPCODE = 12'h02B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_VALID_Inst,
  input  logic [4:0]        in_ROBEN,
  input  logic [4:0]        in_Rd,
  input  logic [11:0]       in_opcode,
  input  logic [31:0]       in_ROBEN2_VAL,
  input  logic [31:0]       in_EA,
  input  logic              ROB_FLUSH_Flag,
  output logic              out_FULL_FLAG,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_CDB_VALID,
  output logic [4:0]        out_CDB_ROBEN,
  output logic [4:0]        out_CDB_Rd,
  output logic [31:0]       out_CDB_VAL,
  output logic              out_CDB_STORE,
  output logic              out_BUSY
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic [4:0]        rob;
    logic [4:0]        rd;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } entry_t;

  entry_t            fifo_mem [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  state_t            state_q, state_d;
  logic              drop_q;
  logic [4:0]        txn_rob_q, txn_rd_q;
  logic              txn_we_q;
  logic [ADDR_W-1:0] txn_addr_q;
  logic [31:0]       txn_wdata_q;
  logic              cdb_valid_q, cdb_store_q;
  logic [4:0]        cdb_rob_q, cdb_rd_q;
  logic [31:0]       cdb_val_q;

  logic   is_ld, is_st, push, pop, ack_fire, cdb_fire;
  entry_t new_entry;

  // Upper address bits are outside the data-memory word space.
  logic unused_ea;
  assign unused_ea = ^in_EA[31:ADDR_W];

  assign is_ld         = (in_opcode == LW_OPCODE);
  assign is_st         = (in_opcode == SW_OPCODE);
  assign out_FULL_FLAG = (count_q == CW'(QDEPTH));
  assign push          = in_VALID_Inst && !out_FULL_FLAG && !ROB_FLUSH_Flag && (is_ld || is_st);

  assign new_entry.rob   = in_ROBEN;
  assign new_entry.rd    = in_Rd;
  assign new_entry.we    = is_st;
  assign new_entry.addr  = in_EA[ADDR_W-1:0];
  assign new_entry.wdata = in_ROBEN2_VAL;

  // Next-state and handshake decode; pop uses the registered count so a
  // freshly pushed entry is never popped on the same edge.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    ack_fire = 1'b0;
    cdb_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !ROB_FLUSH_Flag) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ack_fire = 1'b1;
          cdb_fire = !drop_q && !ROB_FLUSH_Flag;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= new_entry;
  end

  // FIFO pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (ROB_FLUSH_Flag) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FSM state, transaction latch and flush-drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      txn_rob_q   <= '0;
      txn_rd_q    <= '0;
      txn_we_q    <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        txn_rob_q   <= fifo_mem[rd_ptr_q].rob;
        txn_rd_q    <= fifo_mem[rd_ptr_q].rd;
        txn_we_q    <= fifo_mem[rd_ptr_q].we;
        txn_addr_q  <= fifo_mem[rd_ptr_q].addr;
        txn_wdata_q <= fifo_mem[rd_ptr_q].wdata;
      end
      if (ack_fire)                                drop_q <= 1'b0;
      else if (state_q == REQ && ROB_FLUSH_Flag)   drop_q <= 1'b1;
    end
  end

  // CDB broadcast register: one-cycle pulse, all fields zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_rd_q    <= '0;
      cdb_val_q   <= '0;
      cdb_store_q <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_fire;
      cdb_rob_q   <= cdb_fire ? txn_rob_q : 5'd0;
      cdb_rd_q    <= cdb_fire ? txn_rd_q : 5'd0;
      cdb_val_q   <= (cdb_fire && !txn_we_q) ? mem_rdata : 32'd0;
      cdb_store_q <= cdb_fire && txn_we_q;
    end
  end

  assign mem_req       = (state_q == REQ);
  assign mem_we        = txn_we_q;
  assign mem_addr      = txn_addr_q;
  assign mem_wdata     = txn_wdata_q;
  assign out_CDB_VALID = cdb_valid_q;
  assign out_CDB_ROBEN = cdb_rob_q;
  assign out_CDB_Rd    = cdb_rd_q;
  assign out_CDB_VAL   = cdb_val_q;
  assign out_CDB_STORE = cdb_store_q;
  assign out_BUSY      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ld_st_mem_unit.sv
// Directed bench for ld_st_mem_unit: zero-wait load, waited store, FIFO
// fill/drain ordering, flush drop, async reset and illegal opcode.
module tb_ld_st_mem_unit;

  localparam logic [11:0] LW = 12'h023;
  localparam logic [11:0] SW = 12'h02B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_VALID_Inst = 1'b0;
  logic [4:0]  in_ROBEN = '0, in_Rd = '0;
  logic [11:0] in_opcode = '0;
  logic [31:0] in_ROBEN2_VAL = '0, in_EA = '0;
  logic        ROB_FLUSH_Flag = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_FULL_FLAG, mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        out_CDB_VALID, out_CDB_STORE, out_BUSY;
  logic [4:0]  out_CDB_ROBEN, out_CDB_Rd;
  logic [31:0] out_CDB_VAL;

  int passed = 0;
  int total  = 0;
  logic [4:0]  cdb_rob_q [$];
  logic [31:0] cdb_val_q [$];

  ld_st_mem_unit dut (
    .clk(clk), .rst(rst), .in_VALID_Inst(in_VALID_Inst), .in_ROBEN(in_ROBEN),
    .in_Rd(in_Rd), .in_opcode(in_opcode), .in_ROBEN2_VAL(in_ROBEN2_VAL),
    .in_EA(in_EA), .ROB_FLUSH_Flag(ROB_FLUSH_Flag), .out_FULL_FLAG(out_FULL_FLAG),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_CDB_VALID(out_CDB_VALID),
    .out_CDB_ROBEN(out_CDB_ROBEN), .out_CDB_Rd(out_CDB_Rd), .out_CDB_VAL(out_CDB_VAL),
    .out_CDB_STORE(out_CDB_STORE), .out_BUSY(out_BUSY)
  );

  always #5 clk = ~clk;

  // Record every CDB pulse mid-cycle; a one-cycle pulse yields one entry.
  always @(negedge clk) begin
    if (out_CDB_VALID) begin
      cdb_rob_q.push_back(out_CDB_ROBEN);
      cdb_val_q.push_back(out_CDB_VAL);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one edge.
  task automatic issue(input logic [4:0] rob, input logic [4:0] rd, input logic [11:0] op,
                       input logic [31:0] data, input logic [31:0] ea);
    in_VALID_Inst = 1'b1; in_ROBEN = rob; in_Rd = rd; in_opcode = op;
    in_ROBEN2_VAL = data; in_EA = ea;
    tick();
    in_VALID_Inst = 1'b0;
    $display("issue rob=%0d rd=%0d op=%03h data=%08h ea=%08h", rob, rd, op, data, ea);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && out_BUSY; k++) tick();
    tick();
    chk(tag, {31'd0, out_BUSY}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_full", {31'd0, out_FULL_FLAG}, 32'd0);
    chk("rst_cdbv", {31'd0, out_CDB_VALID}, 32'd0);
    chk("rst_cdbrob", {27'd0, out_CDB_ROBEN}, 32'd0);
    chk("rst_busy", {31'd0, out_BUSY}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Zero-wait load
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    issue(5'd3, 5'd8, LW, 32'd0, 32'h0000_0404);
    chk("t1_nopop_same_edge", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", {22'd0, mem_addr}, 32'h004);
    chk("t1_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t1_cdbv", {31'd0, out_CDB_VALID}, 32'd1);
    chk("t1_cdbrob", {27'd0, out_CDB_ROBEN}, 32'd3);
    chk("t1_cdbrd", {27'd0, out_CDB_Rd}, 32'd8);
    chk("t1_cdbval", out_CDB_VAL, 32'hDEAD_BEEF);
    chk("t1_cdbst", {31'd0, out_CDB_STORE}, 32'd0);
    tick();
    chk("t1_cdbv_off", {31'd0, out_CDB_VALID}, 32'd0);
    chk("t1_cdbrob_off", {27'd0, out_CDB_ROBEN}, 32'd0);
    chk("t1_busy", {31'd0, out_BUSY}, 32'd0);
    chk("t1_npulse", cdb_rob_q.size(), 32'd1);
    cdb_rob_q.delete(); cdb_val_q.delete();

    // Store with three wait cycles
    mem_ack = 1'b0;
    issue(5'd5, 5'd0, SW, 32'h1234, 32'h10);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_req%0d", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("t2_addr%0d", i), {22'd0, mem_addr}, 32'h010);
      chk($sformatf("t2_we%0d", i), {31'd0, mem_we}, 32'd1);
      chk($sformatf("t2_wdata%0d", i), mem_wdata, 32'h1234);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("t2_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t2_cdbv", {31'd0, out_CDB_VALID}, 32'd1);
    chk("t2_cdbrob", {27'd0, out_CDB_ROBEN}, 32'd5);
    chk("t2_cdbst", {31'd0, out_CDB_STORE}, 32'd1);
    chk("t2_cdbval", out_CDB_VAL, 32'd0);
    tick();
    cdb_rob_q.delete(); cdb_val_q.delete();

    // Fill: five back-to-back pushes with memory stalled
    mem_ack = 1'b0; mem_rdata = 32'h0000_5A5A;
    for (int i = 0; i < 5; i++) begin
      issue(5'(10 + i), 5'(i + 1), LW, 32'd0, 32'(i * 4));
      chk($sformatf("t3_full%0d", i), {31'd0, out_FULL_FLAG}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk("t3_req", {31'd0, mem_req}, 32'd1);
    chk("t3_addr_head", {22'd0, mem_addr}, 32'd0);
    mem_ack = 1'b1;
    wait_idle("t3_drain");
    mem_ack = 1'b0;
    chk("t3_full_after", {31'd0, out_FULL_FLAG}, 32'd0);
    chk("t3_npulse", cdb_rob_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < cdb_rob_q.size(); i++) begin
      chk($sformatf("t3_order%0d", i), {27'd0, cdb_rob_q[i]}, 32'(10 + i));
      chk($sformatf("t3_val%0d", i), cdb_val_q[i], 32'h0000_5A5A);
    end
    cdb_rob_q.delete(); cdb_val_q.delete();

    // Flush while a load is in REQ with two entries queued behind it
    issue(5'd7, 5'd1, LW, 32'd0, 32'h20);
    issue(5'd8, 5'd2, LW, 32'd0, 32'h24);
    issue(5'd9, 5'd3, LW, 32'd0, 32'h28);
    chk("t4_req", {31'd0, mem_req}, 32'd1);
    ROB_FLUSH_Flag = 1'b1;
    tick();
    ROB_FLUSH_Flag = 1'b0;
    chk("t4_full", {31'd0, out_FULL_FLAG}, 32'd0);
    chk("t4_req_held", {31'd0, mem_req}, 32'd1);
    chk("t4_busy_req", {31'd0, out_BUSY}, 32'd1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t4_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t4_busy_fall", {31'd0, out_BUSY}, 32'd0);
    chk("t4_cdbv", {31'd0, out_CDB_VALID}, 32'd0);
    tick(); tick();
    chk("t4_no_more_req", {31'd0, mem_req}, 32'd0);
    chk("t4_npulse", cdb_rob_q.size(), 32'd0);

    // Async reset mid-REQ with the FIFO full
    for (int i = 0; i < 5; i++) issue(5'(12 + i), 5'd4, LW, 32'd0, 32'h40);
    chk("t5_full_pre", {31'd0, out_FULL_FLAG}, 32'd1);
    chk("t5_req_pre", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_req_async", {31'd0, mem_req}, 32'd0);
    chk("t5_full_async", {31'd0, out_FULL_FLAG}, 32'd0);
    chk("t5_cdbv_async", {31'd0, out_CDB_VALID}, 32'd0);
    chk("t5_busy_async", {31'd0, out_BUSY}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    issue(5'd20, 5'd9, LW, 32'd0, 32'h0000_0FFC);
    for (int k = 0; k < 20 && cdb_rob_q.size() == 0; k++) tick();
    mem_ack = 1'b0;
    chk("t5_npulse", cdb_rob_q.size(), 32'd1);
    if (cdb_rob_q.size() > 0) begin
      chk("t5_rob", {27'd0, cdb_rob_q[0]}, 32'd20);
      chk("t5_val", cdb_val_q[0], 32'hCAFE_0001);
    end
    wait_idle("t5_idle");
    cdb_rob_q.delete(); cdb_val_q.delete();

    // Illegal opcode is silently dropped
    issue(5'd21, 5'd1, 12'h000, 32'd0, 32'h50);
    chk("t6_busy", {31'd0, out_BUSY}, 32'd0);
    tick();
    chk("t6_req", {31'd0, mem_req}, 32'd0);
    chk("t6_busy2", {31'd0, out_BUSY}, 32'd0);
    tick();
    chk("t6_npulse", cdb_rob_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
